// File: rtl/mux2_stream_rr_if.sv
// Signal bundle for the 2:1 round-robin stream mux: two producer streams, one tagged
// consumer stream and the per-source transfer counters.
interface mux2_stream_rr_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in0_data;
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  // Environment side: producers, consumer and counter observer.
  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_sel, out_valid, cnt0, cnt1
  );

  // Mux side.
  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_sel, out_valid, cnt0, cnt1
  );
endinterface

// File: rtl/mux2_stream_rr.sv
// 2:1 valid/ready stream mux with round-robin arbitration, a registered tagged output
// stage and mod-256 per-source accept counters.
module mux2_stream_rr #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  mux2_stream_rr_if.slave  bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [7:0]       cnt0_q, cnt0_d;
  logic [7:0]       cnt1_q, cnt1_d;

  logic load_en;
  logic grant;
  logic acc0;
  logic acc1;

  // Grant only matters when its source is valid; with a single requester it follows that one.
  always_comb begin
    load_en = (state_q == StEmpty) || bus.out_ready;
    grant   = (bus.in0_valid && bus.in1_valid) ? prio_q : bus.in1_valid;
    acc0    = load_en && bus.in0_valid && !grant;
    acc1    = load_en && bus.in1_valid && grant;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (acc0) begin
      state_d = StFull;
      data_d  = bus.in0_data;
      sel_d   = 1'b0;
      prio_d  = 1'b1;
      cnt0_d  = cnt0_q + 8'd1;
    end else if (acc1) begin
      state_d = StFull;
      data_d  = bus.in1_data;
      sel_d   = 1'b1;
      prio_d  = 1'b0;
      cnt1_d  = cnt1_q + 8'd1;
    end else if (state_q == StFull && bus.out_ready) begin
      // Drained with nothing to refill: data and tag keep their last values.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.in0_ready = acc0;
  assign bus.in1_ready = acc1;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state_q == StFull);
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

endmodule

// File: doc/mux2_stream_rr.md
# mux2_stream_rr

Two-input to one-output streaming multiplexer with round-robin arbitration, a registered output stage and per-source transfer counters. It merges two valid/ready producer streams onto a single consumer stream. Each output word carries a source tag, so a downstream 1:2 demultiplexer can route it back by select. It sits between two data producers and a shared datapath or link.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in0_data  input  WIDTH  source 0 data
- in0_valid  input  1  source 0 holds a word
- in0_ready  output  1  source 0 word accepted this cycle when high with in0_valid
- in1_data  input  WIDTH  source 1 data
- in1_valid  input  1  source 1 holds a word
- in1_ready  output  1  source 1 word accepted this cycle when high with in1_valid
- out_data  output  WIDTH  registered output word
- out_sel  output  1  source tag of out_data (0 = in0, 1 = in1)
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer accepts the word this cycle when high with out_valid
- cnt0  output  8  count of words accepted from in0, mod 256
- cnt1  output  8  count of words accepted from in1, mod 256

## Operation
- The output stage has two states, driven by out_valid.
  - EMPTY (out_valid=0): the stage can load.
  - FULL (out_valid=1): the stage holds a word.
- load_en = !out_valid || out_ready. The stage can take a new word on any cycle it is empty or being drained.
- The priority pointer prio is 1 bit and resets to 0. The arbiter grant is combinational:
  - Only in0_valid high: grant 0.
  - Only in1_valid high: grant 1.
  - Both high: grant prio.
  - Neither high: no grant.
- in0_ready = load_en && grant==0 && in0_valid. in1_ready is the same form for source 1.
  - At most one ready is high per cycle.
  - The ready outputs depend combinationally on in*_valid and out_ready. No other combinational path exists.
- On an accepted input transfer from source i:
  - out_data <= ini_data, out_sel <= i, out_valid <= 1.
  - prio <= ~i.
  - cnti <= cnti + 1, wrapping 255 -> 0.
- Output drained (out_valid && out_ready) with no input accepted: out_valid <= 0. out_data and out_sel hold their last values.
- FULL with out_ready=0: out_data, out_sel and out_valid hold stable. Both readies are 0.
- No grant: prio holds.
- Counters increment only on accepted transfers. Stalled valids do not count.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, cnt0=0, cnt1=0, prio=0.
- Reset is applied asynchronously. Release is synchronous to clk.
- Reset asserted mid-operation discards any held word. No partial transfer is reported.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one word per cycle sustained while out_ready=1. There are no bubbles on simultaneous drain and load.
- Both sources continuously valid with out_ready=1: grants alternate 0,1,0,1... starting from prio.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. out_valid stays 1.
- Counter wrap: cnt at 255 plus one accept gives 0. No flag is raised.
- The output holds stable while out_valid=1 and out_ready=0. Consumers may sample at any later cycle.

## Test plan
- Reset mid-stream: hold out_valid=1 with out_ready=0, then pulse rst asynchronously between edges -> out_valid, out_data, out_sel and both counters read 0 immediately; after release the first grant on a tie goes to in0.
- Single source: in0_valid=1 with data 8'hA5, in1_valid=0, out_ready=1 -> the cycle after acceptance shows out_data=A5, out_sel=0, out_valid=1, cnt0=1; cnt1 stays 0.
- Round-robin fairness: both valid for 6 cycles, in0=8'h10, in1=8'h20, out_ready=1 -> out_sel sequence 0,1,0,1,0,1; cnt0=3, cnt1=3; one output per cycle.
- Back-pressure: output FULL with out_ready=0 for 4 cycles, both sources valid -> in0_ready=in1_ready=0, out_data stable, counters unchanged; on out_ready=1 the stage drains and loads in the same cycle.
- Counter wrap: 256 accepted transfers from in1 -> cnt1 returns to 0; cnt0 unaffected.
- Drain without refill: deassert both valids while FULL, then set out_ready=1 -> out_valid falls next cycle; out_data and out_sel hold their last values.
